alu_ctrl_mc: RTL

ALU_CTRL_MC -- requirements
Module: alu_ctrl_mc

---
 rtl/alu_ctrl_pkg.sv | 60 ++++++
 rtl/mul_iter.sv | 49 ++++
 rtl/alu_ctrl_mc.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, R-type funct values and multiply FSM state encoding.
// Used by alu_ctrl_mc with or without ALU_CTRL_MUL_EN defined.
package alu_ctrl_pkg;

  localparam logic [3:0] AluAnd  = 4'd0;
  localparam logic [3:0] AluOr   = 4'd1;
  localparam logic [3:0] AluAdd  = 4'd2;
  localparam logic [3:0] AluOp3  = 4'd3;
  localparam logic [3:0] AluSrl  = 4'd4;
  localparam logic [3:0] AluSrlv = 4'd5;
  localparam logic [3:0] AluSub  = 4'd6;
  localparam logic [3:0] AluSlt  = 4'd7;
  localparam logic [3:0] AluOp8  = 4'd8;
  localparam logic [3:0] AluOp9  = 4'd9;
  localparam logic [3:0] AluMul  = 4'd10;
  localparam logic [3:0] AluOp11 = 4'd11;
  localparam logic [3:0] AluOp13 = 4'd13;

  localparam logic [5:0] FunctAdd  = 6'h20;
  localparam logic [5:0] FunctSub  = 6'h22;
  localparam logic [5:0] FunctAnd  = 6'h24;
  localparam logic [5:0] FunctOr   = 6'h25;
  localparam logic [5:0] FunctSlt  = 6'h2A;
  localparam logic [5:0] FunctSrl  = 6'h02;
  localparam logic [5:0] FunctSrlv = 6'h06;
  localparam logic [5:0] FunctMul  = 6'h18;

  typedef enum logic [1:0] {StIdle, StMulRun, StMulDone} mul_state_e;

  // Unknown funct values fall back to slt; mul only decodes when the multiplier exists.
  function automatic logic [3:0] alu_decode(input logic [2:0] alu_op, input logic [5:0] funct,
                                            input logic mul_en);
    logic [3:0] code;
    code = AluSlt;
    case (alu_op)
      3'd0: code = AluAdd;
      3'd1: code = AluSub;
      3'd2: begin
        case (funct)
          FunctAdd:  code = AluAdd;
          FunctSub:  code = AluSub;
          FunctAnd:  code = AluAnd;
          FunctOr:   code = AluOr;
          FunctSlt:  code = AluSlt;
          FunctSrl:  code = AluSrl;
          FunctSrlv: code = AluSrlv;
          FunctMul:  code = mul_en ? AluMul : AluSlt;
          default:   code = AluSlt;
        endcase
      end
      3'd3: code = AluOp3;
      3'd4: code = AluOp8;
      3'd5: code = AluOp9;
      3'd6: code = AluOp11;
      default: code = AluOp13;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier datapath: one multiplier bit per step, DATA_W-bit
// truncated product. Instantiated by alu_ctrl_mc when ALU_CTRL_MUL_EN is defined.
module mul_iter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] prod_o
);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] prod_q, prod_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (load_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      prod_d   = '0;
    end else if (step_i) begin
      // Bits shifted past DATA_W are dropped, so the sum wraps naturally.
      prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/alu_ctrl_mc.sv
// ALU control decoder with optional iterative multiplier and pipeline stall.
// Define ALU_CTRL_MUL_EN to build the multiply FSM; otherwise funct 0x18 decodes as slt.
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [5:0]        funct_i,
  input  logic [2:0]        ALUOp_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              stall_o,
  output logic              mul_done_o,
  output logic [DATA_W-1:0] mul_result_o
);

`ifdef ALU_CTRL_MUL_EN
  localparam int unsigned CntW = $clog2(DATA_W);

  mul_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] prod;
  logic [3:0]        dec;
  logic              accept, step, done_ok;

  assign dec = alu_decode(ALUOp_i, funct_i, 1'b1);
  // Reset gating keeps stall_o low while reset is held even if a mul is presented.
  assign accept  = rst_i && (state_q == StIdle) && valid_i && !flush_i && (dec == AluMul);
  assign step    = (state_q == StMulRun);
  assign done_ok = (state_q == StMulDone) && !flush_i;

  mul_iter #(
    .DATA_W(DATA_W)
  ) u_mul_iter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(accept),
    .step_i(step),
    .a_i   (src1_i),
    .b_i   (src2_i),
    .prod_o(prod)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StMulRun;
          cnt_d   = '0;
        end
      end
      StMulRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_W - 1)) state_d = StMulDone;
      end
      StMulDone: begin
        state_d = StIdle;
        if (done_ok) result_d = prod;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ALUCtrl_o    = (state_q == StIdle) ? CTRL_W'(dec) : CTRL_W'(AluMul);
  assign stall_o      = accept || (state_q == StMulRun);
  assign mul_done_o   = done_ok;
  assign mul_result_o = done_ok ? prod : result_q;
`else
  logic unused_in;
  assign unused_in = ^{clk_i, rst_i, valid_i, flush_i, src1_i, src2_i};

  assign ALUCtrl_o    = CTRL_W'(alu_decode(ALUOp_i, funct_i, 1'b0));
  assign stall_o      = 1'b0;
  assign mul_done_o   = 1'b0;
  assign mul_result_o = '0;
`endif

endmodule
